// File: rtl/add_pipe_if.sv
// rtl/add_pipe_if.sv - operand/result handshake bundle for add_pipe
// Master drives operands and out_ready; slave (the adder) returns in_ready and results.
interface add_pipe_if #(
  parameter int DATAWIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic                 sub;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] sum;
  logic                 cout;
  logic                 ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined add/subtract, one carry-chained segment per stage
// Optional saturation of the last-stage result: define ADD_PIPE_SAT_EN.
module add_pipe #(
  parameter int DATAWIDTH = 8,
  parameter int STAGES    = 2,
  parameter int SIGNED    = 0
) (
  input  logic      Clk,
  input  logic      Rst,
  add_pipe_if.slave bus
);
  localparam int SEG = DATAWIDTH / STAGES;

  if (STAGES < 1 || (DATAWIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("add_pipe: DATAWIDTH must be a positive multiple of STAGES");
  end
  if (SIGNED != 0 && SIGNED != 1) begin : g_bad_signed
    $error("add_pipe: SIGNED must be 0 or 1");
  end

  // Global stall: the whole pipe moves only when the output slot is free or draining.
  logic advance;
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int WIN = DATAWIDTH - k * SEG;

    logic [WIN-1:0]         ia;
    logic [WIN-1:0]         ib;
    logic                   is;
    logic                   ic;
    logic                   iv;
    logic [SEG-1:0]         bseg;
    logic [SEG:0]           seg;
    logic [(k+1)*SEG-1:0]   nr;
    logic [(k+1)*SEG-1:0]   dnext;
    logic                   q_v;
    logic                   q_c;
    logic [(k+1)*SEG-1:0]   q_r;

    if (k == 0) begin : g_src
      assign ia = bus.a;
      assign ib = bus.b;
      assign is = bus.sub;
      assign ic = bus.sub;
      assign iv = bus.in_valid;
      assign nr = seg[SEG-1:0];
    end else begin : g_src
      assign ia = stg[k-1].g_fwd.q_a;
      assign ib = stg[k-1].g_fwd.q_b;
      assign is = stg[k-1].g_fwd.q_s;
      assign ic = stg[k-1].q_c;
      assign iv = stg[k-1].q_v;
      assign nr = {seg[SEG-1:0], stg[k-1].q_r};
    end

    assign bseg = is ? ~ib[SEG-1:0] : ib[SEG-1:0];
    assign seg  = {1'b0, ia[SEG-1:0]} + {1'b0, bseg} + {{SEG{1'b0}}, ic};

    if (k < STAGES - 1) begin : g_fwd
      // Only the operand segments later stages still need travel on.
      logic [WIN-SEG-1:0] q_a;
      logic [WIN-SEG-1:0] q_b;
      logic               q_s;

      always_ff @(posedge Clk) begin
        if (Rst) begin
          q_a <= '0;
          q_b <= '0;
          q_s <= 1'b0;
        end else if (advance) begin
          q_a <= ia[WIN-1:SEG];
          q_b <= ib[WIN-1:SEG];
          q_s <= is;
        end
      end

      assign dnext = nr;
    end else begin : g_last
      logic a_msb;
      logic b_msb;
      logic ovf_raw;
      logic q_o;

      assign a_msb   = ia[WIN-1];
      assign b_msb   = is ? ~ib[WIN-1] : ib[WIN-1];
      assign ovf_raw = (a_msb == b_msb) && (nr[DATAWIDTH-1] != a_msb);

`ifdef ADD_PIPE_SAT_EN
      // Flags keep the raw carry/overflow; only the data word is clamped.
      always_comb begin
        dnext = nr;
        if (SIGNED != 0) begin
          if (ovf_raw)
            dnext = a_msb ? {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
        end else if (!is && seg[SEG]) begin
          dnext = '1;
        end else if (is && !seg[SEG]) begin
          dnext = '0;
        end
      end
`else
      assign dnext = nr;
`endif

      always_ff @(posedge Clk) begin
        if (Rst)
          q_o <= 1'b0;
        else if (advance)
          q_o <= ovf_raw;
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        q_v <= 1'b0;
        q_c <= 1'b0;
        q_r <= '0;
      end else if (advance) begin
        q_v <= iv;
        q_c <= seg[SEG];
        q_r <= dnext;
      end
    end
  end

  assign bus.out_valid = stg[STAGES-1].q_v;
  assign bus.sum       = stg[STAGES-1].q_r;
  assign bus.cout      = stg[STAGES-1].q_c;
  assign bus.ovf       = stg[STAGES-1].g_last.q_o;
endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - self-checking bench for add_pipe (8/2 unsigned, 8/1 signed, 16/4 signed)
// Shared stimulus, per-instance scoreboards; ADD_PIPE_SAT_EN selects saturated expectations.
module tb_add_pipe;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  add_pipe_if #(.DATAWIDTH(8))  b0 ();
  add_pipe_if #(.DATAWIDTH(8))  b1 ();
  add_pipe_if #(.DATAWIDTH(16)) b2 ();

  add_pipe #(.DATAWIDTH(8),  .STAGES(2), .SIGNED(0)) u0 (.Clk(Clk), .Rst(Rst), .bus(b0.slave));
  add_pipe #(.DATAWIDTH(8),  .STAGES(1), .SIGNED(1)) u1 (.Clk(Clk), .Rst(Rst), .bus(b1.slave));
  add_pipe #(.DATAWIDTH(16), .STAGES(4), .SIGNED(1)) u2 (.Clk(Clk), .Rst(Rst), .bus(b2.slave));

  logic        drv_valid = 1'b0;
  logic [15:0] drv_a = '0;
  logic [15:0] drv_b = '0;
  logic        drv_sub = 1'b0;
  logic [17:0] drv_exp0 = '0;
  logic        out_rdy = 1'b1;
  logic        all_ready;

  assign all_ready = b0.in_ready & b1.in_ready & b2.in_ready;

  assign b0.in_valid = drv_valid & all_ready;
  assign b0.a = drv_a[7:0];
  assign b0.b = drv_b[7:0];
  assign b0.sub = drv_sub;
  assign b0.out_ready = out_rdy;
  assign b1.in_valid = drv_valid & all_ready;
  assign b1.a = drv_a[7:0];
  assign b1.b = drv_b[7:0];
  assign b1.sub = drv_sub;
  assign b1.out_ready = out_rdy;
  assign b2.in_valid = drv_valid & all_ready;
  assign b2.a = drv_a;
  assign b2.b = drv_b;
  assign b2.sub = drv_sub;
  assign b2.out_ready = out_rdy;

  int tests = 0;
  int fails = 0;
  int n0 = 0;
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [17:0] q2[$];

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference result packed as {sum[15:0], cout, ovf}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input int dw, input bit sg);
    logic [16:0] t;
    logic [15:0] mask, aa, bb, r;
    logic c, am, bm, o;
    mask = 16'hFFFF >> (16 - dw);
    aa = a & mask;
    bb = (s ? ~b : b) & mask;
    t = {1'b0, aa} + {1'b0, bb} + 17'(s);
    r = t[15:0] & mask;
    c = t[dw];
    am = aa[dw-1];
    bm = bb[dw-1];
    o = (am == bm) && (r[dw-1] != am);
`ifdef ADD_PIPE_SAT_EN
    if (sg) begin
      if (o) r = am ? (16'h0001 << (dw - 1)) : (mask >> 1);
    end else if (!s && c) begin
      r = mask;
    end else if (s && !c) begin
      r = 16'h0000;
    end
`else
    if (sg && dw == 0) r = 16'h0000;
`endif
    return {r, c, o};
  endfunction

  always @(negedge Clk) begin
    if (Rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      if (b0.out_valid && b0.out_ready) begin
        n0++;
        if (q0.size() == 0) chk("u0 unexpected result", {8'h00, b0.sum, b0.cout, b0.ovf}, 18'h3FFFF);
        else chk("u0 result", {8'h00, b0.sum, b0.cout, b0.ovf}, q0.pop_front());
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) chk("u1 unexpected result", {8'h00, b1.sum, b1.cout, b1.ovf}, 18'h3FFFF);
        else chk("u1 result", {8'h00, b1.sum, b1.cout, b1.ovf}, q1.pop_front());
      end
      if (b2.out_valid && b2.out_ready) begin
        if (q2.size() == 0) chk("u2 unexpected result", {b2.sum, b2.cout, b2.ovf}, 18'h3FFFF);
        else chk("u2 result", {b2.sum, b2.cout, b2.ovf}, q2.pop_front());
      end
      if (drv_valid && all_ready) begin
        q0.push_back(drv_exp0);
        q1.push_back(model(drv_a, drv_b, drv_sub, 8, 1'b1));
        q2.push_back(model(drv_a, drv_b, drv_sub, 16, 1'b1));
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [17:0] e0);
    bit ok;
    ok = 1'b0;
    drv_a = a;
    drv_b = b;
    drv_sub = s;
    drv_exp0 = e0;
    drv_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge Clk);
      if (all_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send timeout", 18'd0, 18'd1);
    @(posedge Clk);
    #1 drv_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge Clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain timeout", 18'd0, 18'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [7:0]  sw;
    logic [7:0]  ss;
    logic        c;
    logic        o;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, lat2, n0s;
    bit done;
    logic [17:0] e;
    logic [15:0] ra, rb;
    logic rs;

    tbl[0] = '{16'h00F0, 16'h0020, 1'b0, 8'h10, 8'hFF, 1'b1, 1'b0};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, 8'hFE, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{16'h007F, 16'h0001, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{16'h0080, 16'h0001, 1'b1, 8'h7F, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{16'h00FF, 16'h0001, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{16'h000F, 16'h0001, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
    tbl[7] = '{16'h0055, 16'h00AA, 1'b1, 8'hAB, 8'h00, 1'b0, 1'b1};
    tbl[8] = '{16'h7FFF, 16'h0001, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
    tbl[9] = '{16'h8000, 16'h0001, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0};

    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("reset out_valid", {17'd0, b0.out_valid}, 18'd0);
    chk("reset sum/cout/ovf", {8'h00, b0.sum, b0.cout, b0.ovf}, 18'd0);
    chk("reset in_ready", {17'd0, b0.in_ready}, 18'd1);
    chk("reset u2 out_valid", {17'd0, b2.out_valid}, 18'd0);
    @(posedge Clk);
    #1;

    // Table vectors, back to back at full rate
    for (int i = 0; i < 10; i++) begin
`ifdef ADD_PIPE_SAT_EN
      e = {8'h00, tbl[i].ss, tbl[i].c, tbl[i].o};
`else
      e = {8'h00, tbl[i].sw, tbl[i].c, tbl[i].o};
`endif
      send(tbl[i].a, tbl[i].b, tbl[i].s, e);
    end
    wait_drain();

    // Latency through an idle pipe
    @(posedge Clk);
    #1;
    send(16'h000F, 16'h0001, 1'b0, {8'h00, 8'h10, 1'b0, 1'b0});
    lat0 = 0;
    lat1 = 0;
    lat2 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (b0.out_valid && lat0 == 0) lat0 = c;
      if (b1.out_valid && lat1 == 0) lat1 = c;
      if (b2.out_valid && lat2 == 0) lat2 = c;
    end
    chk("u0 latency", 18'(lat0), 18'd2);
    chk("u1 latency", 18'(lat1), 18'd1);
    chk("u2 latency", 18'(lat2), 18'd4);
    wait_drain();

    // Stream of four with a three-cycle stall once the first result shows
    @(posedge Clk);
    #1;
    n0s = n0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          send(16'(k), 16'(k), 1'b0, {8'h00, 8'(2 * k), 1'b0, 1'b0});
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
          @(posedge Clk);
          #1;
          if (b0.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) chk("stall first result timeout", 18'd0, 18'd1);
        out_rdy = 1'b0;
        repeat (3) begin
          @(negedge Clk);
          chk("stall in_ready", {17'd0, b0.in_ready}, 18'd0);
          chk("stall out_valid", {17'd0, b0.out_valid}, 18'd1);
          chk("stall sum", {10'd0, b0.sum}, 18'h02);
        end
        @(posedge Clk);
        #1 out_rdy = 1'b1;
      end
    join
    wait_drain();
    chk("stream result count", 18'(n0 - n0s), 18'd4);

    // Reset with two operations in flight
    @(posedge Clk);
    #1;
    send(16'h0011, 16'h0022, 1'b0, {8'h00, 8'h33, 1'b0, 1'b0});
    send(16'h0044, 16'h0011, 1'b1, {8'h00, 8'h33, 1'b1, 1'b0});
    Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    n0s = n0;
    @(negedge Clk);
    chk("post-reset out_valid", {17'd0, b0.out_valid}, 18'd0);
    chk("post-reset sum", {10'd0, b0.sum}, 18'd0);
    chk("post-reset in_ready", {17'd0, b0.in_ready}, 18'd1);
    chk("post-reset u2 out_valid", {17'd0, b2.out_valid}, 18'd0);
    repeat (10) @(negedge Clk);
    chk("no stale result", 18'(n0 - n0s), 18'd0);

    // Random operands under random backpressure
    @(posedge Clk);
    #1;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          ra = 16'($urandom);
          rb = 16'($urandom);
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rs, model(ra, rb, rs, 8, 1'b0));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge Clk);
          #1 out_rdy = 1'($urandom_range(0, 1));
        end
        out_rdy = 1'b1;
      end
    join
    out_rdy = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
